sequence_scanner: RTL and testbench



---
 rtl/sequence_scanner_if.sv | 27 ++
 rtl/sequence_scanner.sv | 162 ++++++++++++++++
 tb/tb_sequence_scanner.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sequence_scanner_if.sv
// Control/status bundle between a scan controller (master) and the sequence scanner (slave).
interface sequence_scanner_if #(
  parameter int MEM_ADDRESS_LENGTH = 6
);
  logic                          start;
  logic                          stop;
  logic [MEM_ADDRESS_LENGTH-1:0] num_rows;
  logic [MEM_ADDRESS_LENGTH-1:0] num_cols;
  logic [15:0]                   dwell;
  logic [MEM_ADDRESS_LENGTH-1:0] row_select;
  logic [MEM_ADDRESS_LENGTH-1:0] col_select;
  logic                          row_col_select;
  logic                          sample_valid;
  logic                          sample_phase;
  logic                          busy;
  logic                          frame_done;

  modport master (
    output start, stop, num_rows, num_cols, dwell,
    input  row_select, col_select, row_col_select, sample_valid, sample_phase, busy, frame_done
  );

  modport slave (
    input  start, stop, num_rows, num_cols, dwell,
    output row_select, col_select, row_col_select, sample_valid, sample_phase, busy, frame_done
  );
endinterface

// File: rtl/sequence_scanner.sv
// Row/column frame scanner: each point gets a row phase then a column phase of dwell cycles.
// Optional SCANNER_LOOP_EN adds a loop_mode input that restarts the frame instead of idling.
module sequence_scanner #(
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int MEM_LENGTH         = 48,
  parameter int PIPE_LATENCY       = 2
) (
  input  logic               clock,
  input  logic               reset_n,
`ifdef SCANNER_LOOP_EN
  input  logic               loop_mode,
`endif
  sequence_scanner_if.slave  scan
);
  localparam int AW = MEM_ADDRESS_LENGTH;
  localparam logic [AW-1:0] MAX_LEN = AW'(MEM_LENGTH);

  typedef enum logic [1:0] {IDLE, ROW_PH, COL_PH} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     row_reg, row_next;
  logic [AW-1:0]     col_reg, col_next;
  logic [15:0]       cnt_reg, cnt_next;
  logic [AW-1:0]     rows_cfg_reg, rows_cfg_next;
  logic [AW-1:0]     cols_cfg_reg, cols_cfg_next;
  logic [15:0]       dwell_cfg_reg, dwell_cfg_next;
  logic              frame_done_reg, frame_done_next;
  logic              busy_reg;
  logic              rcs_reg;
  logic [PIPE_LATENCY-1:0] valid_pipe_reg;
  logic [PIPE_LATENCY-1:0] phase_pipe_reg;
  logic              loop_on;
  logic [15:0]       dwell_eff;
  logic              last_point;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      row_reg        <= '0;
      col_reg        <= '0;
      cnt_reg        <= '0;
      rows_cfg_reg   <= '0;
      cols_cfg_reg   <= '0;
      dwell_cfg_reg  <= '0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
      rcs_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      row_reg        <= row_next;
      col_reg        <= col_next;
      cnt_reg        <= cnt_next;
      rows_cfg_reg   <= rows_cfg_next;
      cols_cfg_reg   <= cols_cfg_next;
      dwell_cfg_reg  <= dwell_cfg_next;
      frame_done_reg <= frame_done_next;
      busy_reg       <= (state_next != IDLE);
      rcs_reg        <= (state_next == COL_PH);
    end
  end

  always_comb begin
    state_next      = state_reg;
    row_next        = row_reg;
    col_next        = col_reg;
    cnt_next        = cnt_reg;
    rows_cfg_next   = rows_cfg_reg;
    cols_cfg_next   = cols_cfg_reg;
    dwell_cfg_next  = dwell_cfg_reg;
    frame_done_next = 1'b0;
`ifdef SCANNER_LOOP_EN
    loop_on         = loop_mode;
`else
    loop_on         = 1'b0;
`endif
    dwell_eff       = (scan.dwell == 16'd0) ? 16'd1 : scan.dwell;
    last_point      = (row_reg == rows_cfg_reg - 1'b1) && (col_reg == cols_cfg_reg - 1'b1);

    case (state_reg)
      IDLE: begin
        if (scan.start && !scan.stop && (scan.num_rows != '0) && (scan.num_cols != '0)) begin
          rows_cfg_next  = (scan.num_rows > MAX_LEN) ? MAX_LEN : scan.num_rows;
          cols_cfg_next  = (scan.num_cols > MAX_LEN) ? MAX_LEN : scan.num_cols;
          dwell_cfg_next = dwell_eff;
          cnt_next       = dwell_eff - 16'd1;
          row_next       = '0;
          col_next       = '0;
          state_next     = ROW_PH;
        end
      end
      ROW_PH: begin
        if (cnt_reg == 16'd0) begin
          cnt_next   = dwell_cfg_reg - 16'd1;
          state_next = COL_PH;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      COL_PH: begin
        if (cnt_reg != 16'd0) begin
          cnt_next = cnt_reg - 16'd1;
        end else if (last_point) begin
          // Frame complete: either idle or wrap straight back into the first row phase.
          frame_done_next = 1'b1;
          row_next        = '0;
          col_next        = '0;
          if (loop_on) begin
            cnt_next   = dwell_cfg_reg - 16'd1;
            state_next = ROW_PH;
          end else begin
            cnt_next   = '0;
            state_next = IDLE;
          end
        end else begin
          cnt_next   = dwell_cfg_reg - 16'd1;
          state_next = ROW_PH;
          if (col_reg == cols_cfg_reg - 1'b1) begin
            col_next = '0;
            row_next = row_reg + 1'b1;
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort overrides everything, including a completing frame's done pulse.
    if (scan.stop && (state_reg != IDLE)) begin
      state_next      = IDLE;
      row_next        = '0;
      col_next        = '0;
      cnt_next        = '0;
      frame_done_next = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_pipe_reg <= '0;
      phase_pipe_reg <= '0;
    end else if (scan.stop) begin
      valid_pipe_reg <= '0;
      phase_pipe_reg <= '0;
    end else begin
      valid_pipe_reg[0] <= busy_reg;
      phase_pipe_reg[0] <= rcs_reg;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        valid_pipe_reg[i] <= valid_pipe_reg[i-1];
        phase_pipe_reg[i] <= phase_pipe_reg[i-1];
      end
    end
  end

  assign scan.row_select     = row_reg;
  assign scan.col_select     = col_reg;
  assign scan.row_col_select = rcs_reg;
  assign scan.busy           = busy_reg;
  assign scan.frame_done     = frame_done_reg;
  assign scan.sample_valid   = valid_pipe_reg[PIPE_LATENCY-1];
  assign scan.sample_phase   = phase_pipe_reg[PIPE_LATENCY-1];
endmodule

// File: tb/tb_sequence_scanner.sv
// Scoreboard bench for sequence_scanner: a frame-level model fills expected queues, monitors pop and compare.
module tb_sequence_scanner;
  localparam int AW = 6;
  localparam int ML = 48;
  localparam int PL = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  sequence_scanner_if #(.MEM_ADDRESS_LENGTH(AW)) bus ();
`ifdef SCANNER_LOOP_EN
  logic loop_mode = 1'b0;
`endif

  sequence_scanner #(
    .MEM_ADDRESS_LENGTH(AW),
    .MEM_LENGTH(ML),
    .PIPE_LATENCY(PL)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
`ifdef SCANNER_LOOP_EN
    .loop_mode(loop_mode),
`endif
    .scan(bus.slave)
  );

  typedef struct {
    int cyc;
    int row;
    int col;
    bit rcs;
    bit busy;
    bit done;
  } out_t;

  typedef struct {
    int cyc;
    bit phase;
  } smp_t;

  out_t exp_q[$];
  smp_t smp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Expected per-cycle behaviour of one frame started in cycle 'base'; stop_at>0 aborts during busy cycle stop_at.
  task automatic push_frame(int base, int rows, int cols, int dwell, bit loop_on, int stop_at);
    int r, c, d, t, last, m, ph;
    out_t o;
    if (rows == 0 || cols == 0) return;
    r = (rows > ML) ? ML : rows;
    c = (cols > ML) ? ML : cols;
    d = (dwell == 0) ? 1 : dwell;
    t = r * c * 2 * d;
    last = (stop_at > 0) ? stop_at : t + 1;
    for (int j = 1; j <= last; j++) begin
      o.cyc = base + j;
      if (stop_at <= 0 && j == t + 1) begin
        o.row = 0; o.col = 0; o.rcs = 0; o.busy = 0; o.done = 1;
      end else begin
        m = (j - 1) % t;
        ph = m / d;
        o.row  = (ph / 2) / c;
        o.col  = (ph / 2) % c;
        o.rcs  = ph[0];
        o.busy = 1;
        o.done = loop_on && (j > 1) && ((j - 1) % t == 0);
      end
      exp_q.push_back(o);
      if (o.busy && (stop_at <= 0 || j <= stop_at - PL))
        smp_q.push_back('{base + j + PL, o.rcs});
    end
  endtask

  always @(negedge clock) begin
    out_t e;
    smp_t s;
    if (reset_n) begin
      if (bus.busy || bus.frame_done) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_unexpected: cyc %0d busy=%0b done=%0b row=%0d col=%0d, required no output",
                   cyc, bus.busy, bus.frame_done, bus.row_select, bus.col_select);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc || int'(bus.row_select) != e.row || int'(bus.col_select) != e.col ||
              bus.row_col_select != e.rcs || bus.busy != e.busy || bus.frame_done != e.done) begin
            n_err++;
            $display("FAIL out: got cyc=%0d row=%0d col=%0d rcs=%0b busy=%0b done=%0b, required cyc=%0d row=%0d col=%0d rcs=%0b busy=%0b done=%0b",
                     cyc, bus.row_select, bus.col_select, bus.row_col_select, bus.busy, bus.frame_done,
                     e.cyc, e.row, e.col, e.rcs, e.busy, e.done);
          end
        end
      end
      if (bus.sample_valid) begin
        n_cmp++;
        if (smp_q.size() == 0) begin
          n_err++;
          $display("FAIL sample_unexpected: cyc %0d sample_valid=1, required 0", cyc);
        end else begin
          s = smp_q.pop_front();
          if (cyc != s.cyc || bus.sample_phase != s.phase) begin
            n_err++;
            $display("FAIL sample: got cyc=%0d phase=%0b, required cyc=%0d phase=%0b",
                     cyc, bus.sample_phase, s.cyc, s.phase);
          end
        end
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || smp_q.size() != 0) && n < 3000) begin
      @(posedge clock);
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || smp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d outputs and %0d samples still pending, required 0 and 0",
               exp_q.size(), smp_q.size());
      exp_q.delete();
      smp_q.delete();
    end
    repeat (PL + 2) @(posedge clock);
  endtask

  task automatic run_frame(int rows, int cols, int dwell, int stop_at, bit loop_on, bit mid_start);
    bit accepted;
    accepted = (rows != 0) && (cols != 0);
    $display("frame rows=%0d cols=%0d dwell=%0d stop_at=%0d loop=%0b", rows, cols, dwell, stop_at, loop_on);
    @(posedge clock); #1;
    bus.num_rows = AW'(rows);
    bus.num_cols = AW'(cols);
    bus.dwell    = 16'(dwell);
    bus.start    = 1'b1;
    push_frame(cyc, rows, cols, dwell, loop_on, stop_at);
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("busy_after_start", int'(bus.busy), int'(accepted));
    if (mid_start) begin
      repeat (3) @(posedge clock);
      #1;
      bus.num_rows = 6'd5;
      bus.num_cols = 6'd5;
      bus.start    = 1'b1;
      @(posedge clock); #1;
      bus.start = 1'b0;
    end
    if (stop_at > 0) begin
      repeat (stop_at - 1) @(posedge clock);
      #1;
      bus.stop = 1'b1;
      @(posedge clock); #1;
      bus.stop = 1'b0;
      check("stop_busy", int'(bus.busy), 0);
      check("stop_row", int'(bus.row_select), 0);
      check("stop_col", int'(bus.col_select), 0);
      check("stop_sample_valid", int'(bus.sample_valid), 0);
    end
    wait_drain();
  endtask

  initial begin
    int r, c, d, t, k;
    bus.start = 0; bus.stop = 0; bus.num_rows = 0; bus.num_cols = 0; bus.dwell = 0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_row", int'(bus.row_select), 0);
    check("rst_sample_valid", int'(bus.sample_valid), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;

    run_frame(2, 3, 4, 0, 0, 1);   // 48 busy cycles, done 49 cycles after start
    run_frame(1, 1, 0, 0, 0, 0);   // dwell 0 acts as 1
    run_frame(60, 0, 1, 0, 0, 0);  // ignored: zero columns
    run_frame(60, 1, 1, 0, 0, 0);  // clamped to 48 rows
    run_frame(4, 4, 2, 4 * 6 + 3, 0, 0);

    // start together with stop is ignored
    @(posedge clock); #1;
    bus.num_rows = 6'd2; bus.num_cols = 6'd2; bus.dwell = 16'd1;
    bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    check("start_with_stop_busy", int'(bus.busy), 0);
    repeat (3) @(posedge clock);

    // asynchronous reset in the column phase of (1,1)
    $display("frame rows=4 cols=4 dwell=2 reset mid-frame");
    @(posedge clock); #1;
    bus.num_rows = 6'd4; bus.num_cols = 6'd4; bus.dwell = 16'd2; bus.start = 1'b1;
    push_frame(cyc, 4, 4, 2, 0, 0);
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (22) @(posedge clock);
    @(negedge clock); #1;
    check("pre_reset_rcs", int'(bus.row_col_select), 1);
    reset_n = 1'b0;
    exp_q.delete();
    smp_q.delete();
    #1;
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_row", int'(bus.row_select), 0);
    check("mid_rst_col", int'(bus.col_select), 0);
    check("mid_rst_rcs", int'(bus.row_col_select), 0);
    check("mid_rst_sample_valid", int'(bus.sample_valid), 0);
    check("mid_rst_sample_phase", int'(bus.sample_phase), 0);
    check("mid_rst_frame_done", int'(bus.frame_done), 0);
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    check("post_rst_idle", int'(bus.busy), 0);
    run_frame(2, 2, 1, 0, 0, 0);

`ifdef SCANNER_LOOP_EN
    loop_mode = 1'b1;
    run_frame(2, 2, 1, 8 * 3 + 2, 1, 0);
    loop_mode = 1'b0;
`endif

    for (int i = 0; i < 10; i++) begin
      r = $urandom_range(0, 5);
      c = $urandom_range(0, 5);
      d = $urandom_range(0, 3);
      t = r * c * 2 * ((d == 0) ? 1 : d);
      k = (t > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, t) : 0;
      run_frame(r, c, d, k, 0, 0);
    end

    check("queues_empty", exp_q.size() + smp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end
endmodule
